// File: rtl/hatch_fetch_if.sv
// rtl/hatch_fetch_if.sv - CPU fetch port and program-memory byte port of hatch_fetch
interface hatch_fetch_if #(
  parameter int INSN_BYTES = 6
);
  logic                    hatch_req;
  logic [31:0]             hatch_address;
  logic [8*INSN_BYTES-1:0] hatch_instruction;
  logic                    hatch_valid;
  logic [31:0]             mem_addr;
  logic                    mem_rd;
  logic [7:0]              mem_rdata;
  logic                    mem_ack;

  // Fetch unit side
  modport slave (
    input  hatch_req, hatch_address, mem_rdata, mem_ack,
    output hatch_instruction, hatch_valid, mem_addr, mem_rd
  );

  // CPU and program-memory side
  modport master (
    output hatch_req, hatch_address, mem_rdata, mem_ack,
    input  hatch_instruction, hatch_valid, mem_addr, mem_rd
  );
endinterface

// File: rtl/hatch_fetch.sv
// rtl/hatch_fetch.sv - six-byte big-endian instruction fetch, optional prefetch buffer (HATCH_PREFETCH_EN)
module hatch_fetch #(
  parameter int INSN_BYTES = 6
) (
  input logic          clk,
  input logic          rst_b,
  hatch_fetch_if.slave bus
);
  localparam int       W    = 8 * INSN_BYTES;
  localparam logic [2:0] LAST = 3'(INSN_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMAND   = 2'd1,
    DELIVER  = 2'd2
`ifdef HATCH_PREFETCH_EN
    ,PREFETCH = 2'd3
`endif
  } state_t;

  state_t       state;
  logic [2:0]   k;
  logic [W-1:0] stage;
  logic [W-1:0] insn_q;
  logic         valid_q;
  logic [31:0]  addr_q;
  logic         rd_q;
  logic [W-1:0] word;

`ifdef HATCH_PREFETCH_EN
  logic [W-1:0] pf_buf;
  logic [31:0]  pf_tag;
  logic         pf_valid;
`endif

  assign bus.hatch_instruction = insn_q;
  assign bus.hatch_valid       = valid_q;
  assign bus.mem_addr          = addr_q;
  assign bus.mem_rd            = rd_q;

  // The last byte arrives straight from memory; the upper five are already staged
  assign word = {stage[W-1:8], bus.mem_rdata};

  // Fetch sequencer: demand fill, one-cycle delivery pulse, optional prefetch fill
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      k       <= '0;
      stage   <= '0;
      insn_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
`ifdef HATCH_PREFETCH_EN
      pf_buf   <= '0;
      pf_tag   <= '0;
      pf_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.hatch_req) begin
`ifdef HATCH_PREFETCH_EN
            // Any request consumes or invalidates the buffer; next prefetch follows it
            pf_valid <= 1'b0;
            pf_tag   <= bus.hatch_address + 32'd6;
            if (pf_valid && pf_tag == bus.hatch_address) begin
              insn_q  <= pf_buf;
              valid_q <= 1'b1;
              state   <= DELIVER;
            end else begin
              addr_q <= bus.hatch_address;
              rd_q   <= 1'b1;
              k      <= '0;
              state  <= DEMAND;
            end
`else
            addr_q <= bus.hatch_address;
            rd_q   <= 1'b1;
            k      <= '0;
            state  <= DEMAND;
`endif
          end
        end

        DEMAND: begin
          if (bus.mem_ack) begin
            if (k == LAST) begin
              insn_q  <= word;
              valid_q <= 1'b1;
              rd_q    <= 1'b0;
              state   <= DELIVER;
            end else begin
              stage[8*(INSN_BYTES-1-int'(k)) +: 8] <= bus.mem_rdata;
              k      <= k + 3'd1;
              addr_q <= addr_q + 32'd1;
            end
          end
        end

        DELIVER: begin
          valid_q <= 1'b0;
`ifdef HATCH_PREFETCH_EN
          addr_q <= pf_tag;
          rd_q   <= 1'b1;
          k      <= '0;
          state  <= PREFETCH;
`else
          state  <= IDLE;
`endif
        end

`ifdef HATCH_PREFETCH_EN
        PREFETCH: begin
          // Nothing moves until the outstanding byte is acked, even when abandoning it
          if (bus.mem_ack) begin
            if (bus.hatch_req && bus.hatch_address != pf_tag) begin
              pf_valid <= 1'b0;
              pf_tag   <= bus.hatch_address + 32'd6;
              addr_q   <= bus.hatch_address;
              k        <= '0;
              state    <= DEMAND;
            end else if (k == LAST) begin
              rd_q <= 1'b0;
              if (bus.hatch_req) begin
                insn_q  <= word;
                valid_q <= 1'b1;
                pf_tag  <= pf_tag + 32'd6;
                state   <= DELIVER;
              end else begin
                pf_buf   <= word;
                pf_valid <= 1'b1;
                state    <= IDLE;
              end
            end else begin
              stage[8*(INSN_BYTES-1-int'(k)) +: 8] <= bus.mem_rdata;
              k      <= k + 3'd1;
              addr_q <= addr_q + 32'd1;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end
endmodule
